// File: rtl/muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_ctrl
// Purpose  : HI/LO multiply/divide sequencer for the execute stage. Accepts
//            MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO requests, runs a
//            multicycle multiply or a 32-iteration restoring divide, stalls
//            the pipeline while busy and owns the architectural HI/LO pair.
//            A flush aborts any in-flight operation and leaves HI/LO intact.
// Ports    : clk, resetn      - clock, asynchronous active-low reset
//            valid_i, op_i    - HI/LO-class instruction present / opcode
//            a_i, b_i         - rs / rt operand values
//            flush_i          - exception/ERET flush of the execute stage
//            stall_o          - hold execute and everything upstream
//            rdata_o          - MFHI/MFLO read data (combinational)
//            hi_o, lo_o       - architectural HI and LO
//            busy_o           - multiply or divide in flight
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_ctrl #(
    parameter int MUL_LAT   = 2,
    parameter int DIV_ITERS = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        valid_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic [31:0] rdata_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        busy_o
);

    localparam logic [2:0] c_op_mthi = 3'd4;
    localparam logic [2:0] c_op_mtlo = 3'd5;
    localparam logic [2:0] c_op_mfhi = 3'd6;
    localparam logic [2:0] c_op_mflo = 3'd7;

    localparam logic [5:0] c_mul_last = 6'(MUL_LAT - 1);
    localparam logic [5:0] c_div_last = 6'(DIV_ITERS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q,   cnt_d;
    logic [31:0] a_q,     a_d;      // multiplicand
    logic [31:0] b_q,     b_d;      // multiplier, or |divisor| for a divide
    logic        sgn_q,   sgn_d;    // signed multiply
    logic        qneg_q,  qneg_d;   // negate quotient at commit
    logic        rneg_q,  rneg_d;   // negate remainder at commit
    logic [31:0] rem_q,   rem_d;    // partial remainder
    logic [31:0] quo_q,   quo_d;    // dividend shifting out / quotient shifting in
    logic [31:0] hi_q,    hi_d;
    logic [31:0] lo_q,    lo_d;

    logic        stall;

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    logic        w_op_signed;
    logic        w_start;
    logic [31:0] w_a_abs;
    logic [31:0] w_b_abs;
    logic [63:0] w_ma;
    logic [63:0] w_mb;
    logic [63:0] w_prod;
    logic [32:0] w_shift;
    logic [32:0] w_diff;
    logic        w_ge;
    logic [31:0] w_rem_nx;
    logic [31:0] w_quo_nx;

    // MULT and DIV have op[0]=0; their unsigned twins have op[0]=1.
    assign w_op_signed = ~op_i[0];
    // Multiply/divide opcodes all have op[2]=0.
    assign w_start     = valid_i & ~flush_i & ~op_i[2];

    assign w_a_abs = (w_op_signed & a_i[31]) ? (32'd0 - a_i) : a_i;
    assign w_b_abs = (w_op_signed & b_i[31]) ? (32'd0 - b_i) : b_i;

    // Extend both operands to 64 bits so one unsigned multiply serves both
    // signed and unsigned forms; the low 64 bits of the product are exact.
    assign w_ma   = sgn_q ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
    assign w_mb   = sgn_q ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
    assign w_prod = w_ma * w_mb;

    // One restoring-divide step: bring in the next dividend bit, trial
    // subtract, keep the difference only when it did not go negative.
    // The shifted remainder is always below twice the divisor, so bit 32
    // of the 33-bit difference is a reliable sign.
    assign w_shift  = {rem_q, quo_q[31]};
    assign w_diff   = w_shift - {1'b0, b_q};
    assign w_ge     = ~w_diff[32];
    assign w_rem_nx = w_ge ? w_diff[31:0] : w_shift[31:0];
    assign w_quo_nx = {quo_q[30:0], w_ge};

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        stall   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_start) begin
                    stall  = 1'b1;
                    cnt_d  = 6'd0;
                    a_d    = a_i;
                    b_d    = b_i;
                    sgn_d  = w_op_signed;
                    qneg_d = 1'b0;
                    rneg_d = 1'b0;
                    if (!op_i[1]) begin
                        state_d = S_MUL;
                    end else if (b_i == 32'd0) begin
                        // Divide by zero: architecturally undefined, HI/LO kept.
                        state_d = S_DONE;
                    end else begin
                        state_d = S_DIV;
                        b_d     = w_b_abs;
                        quo_d   = w_a_abs;
                        rem_d   = 32'd0;
                        qneg_d  = w_op_signed & (a_i[31] ^ b_i[31]);
                        rneg_d  = w_op_signed & a_i[31];
                    end
                end else if (valid_i && !flush_i && op_i == c_op_mthi) begin
                    hi_d = a_i;
                end else if (valid_i && !flush_i && op_i == c_op_mtlo) begin
                    lo_d = a_i;
                end
            end

            S_MUL: begin
                stall = 1'b1;
                if (cnt_q == c_mul_last) begin
                    hi_d    = w_prod[63:32];
                    lo_d    = w_prod[31:0];
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end

            S_DIV: begin
                stall = 1'b1;
                rem_d = w_rem_nx;
                quo_d = w_quo_nx;
                if (cnt_q == c_div_last) begin
                    // Magnitude result with signs restored; 0x80000000 / -1
                    // wraps naturally to 0x80000000 with remainder 0.
                    lo_d    = qneg_q ? (32'd0 - w_quo_nx) : w_quo_nx;
                    hi_d    = rneg_q ? (32'd0 - w_rem_nx) : w_rem_nx;
                    state_d = S_IDLE == S_IDLE ? S_DONE : S_DONE;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end

            S_DONE: begin
                // The stalled instruction retires this cycle; its valid_i
                // is still visible and must not restart the operation.
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Flush wins over start, commit and MT writes.
        if (flush_i) begin
            state_d = S_IDLE;
            cnt_d   = 6'd0;
            hi_d    = hi_q;
            lo_d    = lo_q;
            stall   = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= 6'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            sgn_q   <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            rem_q   <= 32'd0;
            quo_q   <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // While reset is held no request can be accepted, so the pipeline is
    // released immediately rather than seeing a start-cycle stall.
    assign stall_o = stall & resetn;
    assign busy_o  = (state_q == S_MUL) || (state_q == S_DIV);
    assign hi_o    = hi_q;
    assign lo_o    = lo_q;

    always_comb begin
        rdata_o = 32'd0;
        if (op_i == c_op_mfhi) begin
            rdata_o = hi_q;
        end else if (op_i == c_op_mflo) begin
            rdata_o = lo_q;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_ctrl
// Purpose  : Self-checking bench for muldiv_ctrl. Directed scenarios plus a
//            randomized instruction stream compared against an arithmetic
//            reference model of HI/LO and the expected stall length.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_ctrl;

    localparam int MUL_LAT = 2;

    logic        clk;
    logic        resetn;
    logic        valid_i;
    logic [2:0]  op_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        flush_i;
    logic        stall_o;
    logic [31:0] rdata_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        busy_o;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_hi;
    logic [31:0] m_lo;

    muldiv_ctrl #(
        .MUL_LAT   (MUL_LAT),
        .DIV_ITERS (32)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .valid_i (valid_i),
        .op_i    (op_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .flush_i (flush_i),
        .stall_o (stall_o),
        .rdata_o (rdata_o),
        .hi_o    (hi_o),
        .lo_o    (lo_o),
        .busy_o  (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    task automatic model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            inout logic [31:0] h, inout logic [31:0] l);
        longint      sp;
        longint      sa;
        longint      sb;
        logic [63:0] up;
        case (op)
            3'd0: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                {h, l} = 64'(sp);
            end
            3'd1: begin
                up = {32'd0, a} * {32'd0, b};
                {h, l} = up;
            end
            3'd2: if (b != 32'd0) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                l  = 32'(sa / sb);
                h  = 32'(sa % sb);
            end
            3'd3: if (b != 32'd0) begin
                l = a / b;
                h = a % b;
            end
            3'd4: h = a;
            3'd5: l = a;
            default: ;
        endcase
    endtask

    function automatic int exp_stall(input logic [2:0] op, input logic [31:0] b);
        if (op <= 3'd1) return 1 + MUL_LAT;
        if (op <= 3'd3) return (b == 32'd0) ? 1 : 33;
        return 0;
    endfunction

    // Present an instruction (called just after a rising edge) and count the
    // cycles stall_o holds it. Returns at the negedge of the cycle in which it
    // advances; -1 means the stall never released.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int nstall);
        bit released;
        valid_i  = 1'b1;
        op_i     = op;
        a_i      = a;
        b_i      = b;
        nstall   = 0;
        released = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!stall_o) begin
                released = 1'b1;
                break;
            end
            nstall++;
        end
        if (!released) nstall = -1;
    endtask

    task automatic retire;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        op_i    = 3'd0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        resetn  = 1'b0;
        valid_i = 1'b1;
        op_i    = 3'd6;
        a_i     = 32'hDEAD_BEEF;
        b_i     = 32'h1234_5678;
        flush_i = 1'b0;
        #3;
        checks++;
        if (rdata_o !== 32'd0 || stall_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_mfhi rdata=%h stall=%b busy=%b required rdata=0 stall=0 busy=0",
                     rdata_o, stall_o, busy_o);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        op_i   = 3'd7;
        #1;
        checks++;
        if (rdata_o !== 32'd0 || stall_o !== 1'b0 || hi_o !== 32'd0 || lo_o !== 32'd0) begin
            errors++;
            $display("FAIL reset_mflo rdata=%h stall=%b hi=%h lo=%h required all 0",
                     rdata_o, stall_o, hi_o, lo_o);
        end
        m_hi = 32'd0;
        m_lo = 32'd0;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
    endtask

    task automatic test_mul;
        int n;
        run_op(3'd0, 32'hFFFF_FFFE, 32'd3, n);
        retire();
        checks++;
        if (n !== 3 || hi_o !== 32'hFFFF_FFFF || lo_o !== 32'hFFFF_FFFA) begin
            errors++;
            $display("FAIL mult stall=%0d hi=%h lo=%h required stall=3 hi=ffffffff lo=fffffffa",
                     n, hi_o, lo_o);
        end
        run_op(3'd1, 32'hFFFF_FFFE, 32'd3, n);
        retire();
        checks++;
        if (n !== 3 || hi_o !== 32'h0000_0002 || lo_o !== 32'hFFFF_FFFA) begin
            errors++;
            $display("FAIL multu stall=%0d hi=%h lo=%h required stall=3 hi=00000002 lo=fffffffa",
                     n, hi_o, lo_o);
        end
        m_hi = 32'h0000_0002;
        m_lo = 32'hFFFF_FFFA;
    endtask

    task automatic test_div;
        int n;
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, n);
        retire();
        checks++;
        if (n !== 33 || lo_o !== 32'hFFFF_FFFD || hi_o !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL div_neg stall=%0d hi=%h lo=%h required stall=33 hi=ffffffff lo=fffffffd",
                     n, hi_o, lo_o);
        end
        run_op(3'd3, 32'd100, 32'd7, n);
        retire();
        checks++;
        if (n !== 33 || lo_o !== 32'd14 || hi_o !== 32'd2) begin
            errors++;
            $display("FAIL divu stall=%0d hi=%h lo=%h required stall=33 hi=2 lo=14", n, hi_o, lo_o);
        end
        m_hi = 32'd2;
        m_lo = 32'd14;
    endtask

    task automatic test_div_edges;
        int n;
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, n);
        retire();
        checks++;
        if (n !== 33 || lo_o !== 32'h8000_0000 || hi_o !== 32'd0) begin
            errors++;
            $display("FAIL div_ovf stall=%0d hi=%h lo=%h required stall=33 hi=0 lo=80000000",
                     n, hi_o, lo_o);
        end
        run_op(3'd3, 32'd55, 32'd0, n);
        retire();
        checks++;
        if (n !== 1 || lo_o !== 32'h8000_0000 || hi_o !== 32'd0) begin
            errors++;
            $display("FAIL divu_zero stall=%0d hi=%h lo=%h required stall=1 hi=0 lo=80000000",
                     n, hi_o, lo_o);
        end
        m_hi = 32'd0;
        m_lo = 32'h8000_0000;
    endtask

    task automatic test_flush;
        valid_i = 1'b1;
        op_i    = 3'd2;
        a_i     = 32'd1000;
        b_i     = 32'd3;
        repeat (11) @(posedge clk);
        #1;
        flush_i = 1'b1;
        @(negedge clk);
        checks++;
        if (stall_o !== 1'b0 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL flush_comb stall=%b busy=%b required stall=0 busy=1", stall_o, busy_o);
        end
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        valid_i = 1'b0;
        #1;
        checks++;
        if (busy_o !== 1'b0 || stall_o !== 1'b0 || hi_o !== m_hi || lo_o !== m_lo) begin
            errors++;
            $display("FAIL flush_abort busy=%b stall=%b hi=%h lo=%h required busy=0 stall=0 hi=%h lo=%h",
                     busy_o, stall_o, hi_o, lo_o, m_hi, m_lo);
        end
        @(posedge clk);
        #1;
        valid_i = 1'b1;
        op_i    = 3'd5;
        a_i     = 32'h0000_1234;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        checks++;
        if (lo_o !== 32'h0000_1234 || hi_o !== m_hi) begin
            errors++;
            $display("FAIL mtlo_after_flush lo=%h hi=%h required lo=00001234 hi=%h", lo_o, hi_o, m_hi);
        end
        m_lo = 32'h0000_1234;
        // MT blocked by a same-cycle flush.
        valid_i = 1'b1;
        op_i    = 3'd4;
        a_i     = 32'hCAFE_0001;
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        flush_i = 1'b0;
        checks++;
        if (hi_o !== m_hi) begin
            errors++;
            $display("FAIL mthi_flushed hi=%h required %h", hi_o, m_hi);
        end
    endtask

    task automatic test_mul_then_mflo;
        int n;
        valid_i = 1'b1;
        op_i    = 3'd0;
        a_i     = 32'd7;
        b_i     = 32'hFFFF_FFFA;
        @(posedge clk);
        #1;
        checks++;
        if (busy_o !== 1'b1 || stall_o !== 1'b1) begin
            errors++;
            $display("FAIL mul_busy busy=%b stall=%b required 1 1", busy_o, stall_o);
        end
        run_op(3'd0, 32'd7, 32'hFFFF_FFFA, n);
        checks++;
        if (n !== MUL_LAT || lo_o !== 32'hFFFF_FFD6) begin
            errors++;
            $display("FAIL mul_done_visible stall=%0d lo=%h required stall=%0d lo=ffffffd6",
                     n, lo_o, MUL_LAT);
        end
        @(posedge clk);
        #1;
        op_i = 3'd7;
        @(negedge clk);
        checks++;
        if (stall_o !== 1'b0 || rdata_o !== 32'hFFFF_FFD6) begin
            errors++;
            $display("FAIL mflo_after_mul stall=%b rdata=%h required stall=0 rdata=ffffffd6",
                     stall_o, rdata_o);
        end
        retire();
        m_hi = 32'hFFFF_FFFF;
        m_lo = 32'hFFFF_FFD6;
    endtask

    task automatic test_reset_mid_mul;
        valid_i = 1'b1;
        op_i    = 3'd1;
        a_i     = 32'h1234_5678;
        b_i     = 32'h9ABC_DEF0;
        @(posedge clk);
        #1;
        resetn = 1'b0;
        #1;
        checks++;
        if (hi_o !== 32'd0 || lo_o !== 32'd0 || stall_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_mul hi=%h lo=%h stall=%b busy=%b required all 0",
                     hi_o, lo_o, stall_o, busy_o);
        end
        valid_i = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        m_hi = 32'd0;
        m_lo = 32'd0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random;
        int          n;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_rd;
        for (int k = 0; k < 24; k++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'd0;
            if ($urandom_range(0, 3) == 0) a = 32'h8000_0000;
            if ($urandom_range(0, 3) == 0) b = 32'(-int'($urandom_range(1, 20)));
            exp_rd = (op == 3'd6) ? m_hi : ((op == 3'd7) ? m_lo : 32'd0);
            run_op(op, a, b, n);
            checks++;
            if (n !== exp_stall(op, b) || rdata_o !== exp_rd) begin
                errors++;
                $display("FAIL rand_stall op=%0d a=%h b=%h stall=%0d rdata=%h required stall=%0d rdata=%h",
                         op, a, b, n, rdata_o, exp_stall(op, b), exp_rd);
            end
            retire();
            model_op(op, a, b, m_hi, m_lo);
            checks++;
            if (hi_o !== m_hi || lo_o !== m_lo) begin
                errors++;
                $display("FAIL rand_hilo op=%0d a=%h b=%h hi=%h lo=%h required hi=%h lo=%h",
                         op, a, b, hi_o, lo_o, m_hi, m_lo);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_div_edges();
        test_flush();
        test_mul_then_mflo();
        test_reset_mid_mul();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
